c_hazard_unit: RTL

Pipeline hazard controller for the five-stage core. It drives the stall and flush inputs of every pipeline register, including StallD/FlushD of the IF/ID register. It also drives the E-stage operand forwarding selects. It sequences multi-cycle multiply/divide operations in E with an internal down-counter, and freezes the pipe on data-memory wait states.

---
 rtl/c_hazard_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/c_hazard_unit.sv
// Hazard controller for the five-stage core: operand forwarding, load-use and
// branch handling, multi-cycle MDU sequencing and data-memory wait-state freezes.
module c_hazard_unit #(
    parameter int MDU_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic [4:0] Rd_M,
    input  logic [4:0] Rd_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       ResultSrcb0_E,
    input  logic       PCSrc_E,
    input  logic       MduOp_E,
    input  logic       MemReq_M,
    input  logic       MemReady_M,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       MduStart_E,
    output logic       MduBusy
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;
    localparam logic       MULTI    = (MDU_CYCLES > 1);
    // Busy cycles remaining after the first one; the final busy cycle sees cnt==0.
    localparam logic [3:0] CNT_LOAD = 4'(MDU_CYCLES - 2);

    logic [0:0] state;
    logic [3:0] cnt;
    logic       memstall;
    logic       lduse;
    logic       mdustall;
    logic       in_run;
    logic       in_busy;

    assign in_run   = (state == RUN);
    assign in_busy  = (state == MDU_BUSY);
    assign memstall = MemReq_M & ~MemReady_M;
    assign lduse    = ResultSrcb0_E & (Rd_E != 5'd0) & ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));
    assign mdustall = (in_run & MduOp_E & MULTI) | (in_busy & (cnt != 4'd0));

    // Forwarding ignores stalls and reset; M is newer than W so it wins.
    always_comb begin
        ForwardA_E = 2'b00;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
            ForwardA_E = 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
            ForwardA_E = 2'b01;
    end

    always_comb begin
        ForwardB_E = 2'b00;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
            ForwardB_E = 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
            ForwardB_E = 2'b01;
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            if (memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (mdustall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrc_E) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lduse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MduStart_E = ~reset & in_run & MduOp_E & ~memstall;
    assign MduBusy    = ~reset & in_busy;

    // A memory wait freezes the sequencer, so an op entering E is not recognised yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else if (!memstall) begin
            case (state)
                RUN: begin
                    if (MduOp_E && MULTI) begin
                        state <= MDU_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= RUN;
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
